// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, load extraction, writeback mux and retired-instruction counter
module wb_stage #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_regwrite,
  input  logic [4:0]       in_rd,
  input  logic [1:0]       in_wbsel,
  input  logic [2:0]       in_funct3,
  input  logic [31:0]      in_alu_result,
  input  logic [31:0]      in_mem_rdata,
  input  logic [31:0]      in_pc_plus4,
  output logic             regwrite,
  output logic [4:0]       writereg_addr,
  output logic [31:0]      writedata,
  output logic             wb_retire,
  output logic [CNT_W-1:0] instret
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic        valid_q, regwrite_q;
  logic [4:0]  rd_q;
  logic [1:0]  wbsel_q;
  logic [2:0]  funct3_q;
  logic [31:0] alu_q, rdata_q, pc4_q;
  logic [31:0] shifted, load_v;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  // pipeline register (flush beats stall, reset beats both) and retire counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wbsel_q    <= '0;
      funct3_q   <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      instret    <= '0;
    end else begin
      if (flush) begin
        valid_q    <= 1'b0;
        regwrite_q <= 1'b0;
      end else if (!stall) begin
        valid_q    <= in_valid;
        regwrite_q <= in_regwrite;
        rd_q       <= in_rd;
        wbsel_q    <= in_wbsel;
        funct3_q   <= in_funct3;
        alu_q      <= in_alu_result;
        rdata_q    <= in_mem_rdata;
        pc4_q      <= in_pc_plus4;
      end
      if (wb_retire) instret <= instret + ONE;
    end
  end
  // load extraction and writeback source selection
  always_comb begin
    shifted       = rdata_q >> {alu_q[1:0], 3'b000};
    byte_v        = shifted[7:0];
    half_v        = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    load_v        = funct3_q == 3'b000 ? {{24{byte_v[7]}}, byte_v} :
                    funct3_q == 3'b100 ? {24'b0, byte_v} :
                    funct3_q == 3'b001 ? {{16{half_v[15]}}, half_v} :
                    funct3_q == 3'b101 ? {16'b0, half_v} : rdata_q;
    writedata     = wbsel_q == 2'b01 ? load_v : wbsel_q == 2'b10 ? pc4_q : alu_q;
    regwrite      = valid_q & regwrite_q & (rd_q != 5'd0);
    writereg_addr = rd_q;
    wb_retire     = valid_q & (~stall | flush);
  end
endmodule
